ucode_sequencer: RTL and testbench
==================================

# ucode_sequencer

Registered micro-code sequencer for the multi-cycle RV32I(M) core. Accepts one 32-bit instruction per valid/ready handshake and decodes it to a micro-code entry address. It then walks the micro-PC through the external micro-code ROM until the ROM flags the last micro-op, applying downstream backpressure throughout. It adds parametrised address width and entry spacing, optional M-extension entries, a runaway-sequence watchdog and a trap path.

## Interface
Parameters:
- UADDR_W, 6: micro-address width; must be ≥ 6 + ENTRY_SHIFT.
- ENTRY_SHIFT, 0: entry address = entry index << ENTRY_SHIFT, reserving 2^ENTRY_SHIFT slots per entry.
- ENABLE_M, 0: 1 = decode RV32M (funct7 0000001, opcode 0110011) to indices 27..34 by funct3; 0 = illegal.
- MAX_STEPS, 8: maximum accepted micro-ops per sequence before watchdog trap.
- TRAP_ADDR, all ones (UADDR_W bits): micro-address issued on trap.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  sequencer can accept an instruction.
- instr  in  32  instruction word.
- uop_valid  out  1  uop_addr valid.
- uop_ready  in  1  datapath consumes the current micro-op.
- uop_last  in  1  ROM end-of-sequence bit for the current uop_addr; combinational from the ROM.
- uop_addr  out  UADDR_W  micro-PC.
- instr_q  out  32  latched instruction, held for the whole sequence.
- uop_illegal  out  1  current sequence came from an illegal encoding.
- fault  out  1  sticky watchdog/wrap fault.

## Operation
- Entry indices: ADD 1, SUB 2, AND 3, OR 4, XOR 5, SLL 6, SRL 7, SRA 8, SLT 9, SLTU 10, LOAD 11, STORE 12, BRANCH 13, ADDI 14, SLTI 15, SLTIU 16, XORI 17, ORI 18, ANDI 19, SLLI 20, SRLI 21, SRAI 22, LUI 23 (0110111), AUIPC 24, JAL 25, JALR 26, M ops 27..34, illegal 63.
- Illegal conditions: any unlisted opcode; any funct7 not matching its op; SLLI with funct7 ≠ 0. Index 63 also sets uop_illegal for the sequence.
- States:
  - IDLE: instr_ready = 1. On handshake, latch instr_q, set uop_addr = entry, clear step count, go to RUN.
  - RUN: uop_valid = 1. On uop handshake:
    - uop_last = 1: go to IDLE, or directly to the next entry if an instruction handshake occurs in the same cycle.
    - else if step count + 1 == MAX_STEPS or uop_addr is all ones: set fault, go to TRAP.
    - else uop_addr increments and step count increments.
  - TRAP: uop_valid = 1, uop_addr = TRAP_ADDR. On handshake, go to IDLE; uop_last is ignored.
- instr_ready = (IDLE) or (RUN & uop_valid & uop_ready & uop_last), and is 0 while reset is high.
- fault clears only on reset.

## Timing
- All outputs registered except instr_ready, which is combinational from state, uop_ready and uop_last.
- Latency: instruction handshake at cycle N gives uop_valid with the entry address at N+1.
- Back-to-back instructions run with no bubble.
- With uop_ready = 0, uop_addr, instr_q and uop_illegal hold stable.
- Reset values: uop_valid 0, uop_addr 0, instr_q 0, uop_illegal 0, fault 0, state IDLE.
- Reset asserted mid-sequence aborts it; the first instruction is accepted on the cycle after reset deasserts.
- Micro-PC arithmetic is UADDR_W bits unsigned; wrap past all ones never occurs because it traps first.

## Structure
- Shared package ucode_pkg holds:
  - opcode constants;
  - entry index constants (including ILLEGAL = 63);
  - state enum {IDLE, RUN, TRAP};
  - index→address shift function.
- One combinational sub-module, rv32_entry_decode (instr, ENABLE_M → 6-bit index, illegal flag), instantiated once in front of the IDLE latch.

## Test plan
- add x3,x1,x2 (0x002081B3), uop_last = 1, uop_ready = 1 → uop_addr = 1 one cycle after accept; uop_illegal = 0; back to IDLE.
- UADDR_W = 8, ENTRY_SHIFT = 2; lw x3,0(x1) (0x0000A183); uop_last on third micro-op → uop_addr 44, 45, 46, then instr_ready = 1.
- mul x3,x1,x2 (0x022081B3):
  - ENABLE_M = 1 → uop_addr = 27.
  - ENABLE_M = 0 → uop_addr = 63, uop_illegal = 1.
- MAX_STEPS = 8, uop_last held 0 → 8 addresses from the entry, then uop_addr = TRAP_ADDR and fault = 1 (sticky after IDLE).
- Backpressure and back-to-back: uop_ready low 3 cycles holds uop_addr and instr_q. A second instruction offered during a last micro-op is accepted that cycle, and its entry appears next cycle with no bubble.
- Reset pulsed during RUN → next cycle uop_valid = 0, uop_addr = 0, fault = 0; a following ADD issues entry 1 normally.

Source files
------------

// File: rtl/ucode_sequencer_pkg.sv
// Shared constants for the micro-code sequencer: opcodes, entry indices,
// sequencer states and the entry-index to micro-address mapping.
package ucode_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [5:0] IDX_ADD    = 6'd1;
    localparam logic [5:0] IDX_SUB    = 6'd2;
    localparam logic [5:0] IDX_AND    = 6'd3;
    localparam logic [5:0] IDX_OR     = 6'd4;
    localparam logic [5:0] IDX_XOR    = 6'd5;
    localparam logic [5:0] IDX_SLL    = 6'd6;
    localparam logic [5:0] IDX_SRL    = 6'd7;
    localparam logic [5:0] IDX_SRA    = 6'd8;
    localparam logic [5:0] IDX_SLT    = 6'd9;
    localparam logic [5:0] IDX_SLTU   = 6'd10;
    localparam logic [5:0] IDX_LOAD   = 6'd11;
    localparam logic [5:0] IDX_STORE  = 6'd12;
    localparam logic [5:0] IDX_BRANCH = 6'd13;
    localparam logic [5:0] IDX_ADDI   = 6'd14;
    localparam logic [5:0] IDX_SLTI   = 6'd15;
    localparam logic [5:0] IDX_SLTIU  = 6'd16;
    localparam logic [5:0] IDX_XORI   = 6'd17;
    localparam logic [5:0] IDX_ORI    = 6'd18;
    localparam logic [5:0] IDX_ANDI   = 6'd19;
    localparam logic [5:0] IDX_SLLI   = 6'd20;
    localparam logic [5:0] IDX_SRLI   = 6'd21;
    localparam logic [5:0] IDX_SRAI   = 6'd22;
    localparam logic [5:0] IDX_LUI    = 6'd23;
    localparam logic [5:0] IDX_AUIPC  = 6'd24;
    localparam logic [5:0] IDX_JAL    = 6'd25;
    localparam logic [5:0] IDX_JALR   = 6'd26;
    localparam logic [5:0] IDX_M_BASE = 6'd27;
    localparam logic [5:0] IDX_ILLEGAL = 6'd63;

    typedef enum logic [1:0] {IDLE, RUN, TRAP} state_t;

    // Each entry owns 2^shift consecutive ROM slots; caller truncates to UADDR_W.
    function automatic logic [31:0] entry_addr(input logic [5:0] idx, input int shift);
        return {26'd0, idx} << shift;
    endfunction

endpackage

// File: rtl/ucode_sequencer_if.sv
// Instruction-in / micro-op-out bus of the sequencer. master is the
// sequencer side, slave is the fetch/datapath/ROM side.
interface ucode_sequencer_if #(parameter int UADDR_W = 6) ();
    logic               instr_valid;
    logic               instr_ready;
    logic [31:0]        instr;
    logic               uop_valid;
    logic               uop_ready;
    logic               uop_last;
    logic [UADDR_W-1:0] uop_addr;
    logic [31:0]        instr_q;
    logic               uop_illegal;
    logic               fault;

    modport master (
        input  instr_valid, instr, uop_ready, uop_last,
        output instr_ready, uop_valid, uop_addr, instr_q, uop_illegal, fault
    );

    modport slave (
        output instr_valid, instr, uop_ready, uop_last,
        input  instr_ready, uop_valid, uop_addr, instr_q, uop_illegal, fault
    );
endinterface

// File: rtl/ucode_sequencer_entry_decode.sv
// Combinational RV32I(M) decode of an instruction word to its micro-code
// entry index; anything not recognised maps to the illegal entry.
module rv32_entry_decode
    import ucode_pkg::*;
#(
    parameter int ENABLE_M = 0
) (
    input  logic [31:0] instr,
    output logic [5:0]  idx,
    output logic        illegal
);
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       unused_fields;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    always_comb begin
        idx = IDX_ILLEGAL;
        unique case (opcode)
            OPC_OP: begin
                if (funct7 == F7_BASE) begin
                    unique case (funct3)
                        3'd0: idx = IDX_ADD;
                        3'd1: idx = IDX_SLL;
                        3'd2: idx = IDX_SLT;
                        3'd3: idx = IDX_SLTU;
                        3'd4: idx = IDX_XOR;
                        3'd5: idx = IDX_SRL;
                        3'd6: idx = IDX_OR;
                        default: idx = IDX_AND;
                    endcase
                end else if (funct7 == F7_ALT) begin
                    if (funct3 == 3'd0)      idx = IDX_SUB;
                    else if (funct3 == 3'd5) idx = IDX_SRA;
                end else if (funct7 == F7_MULDIV && ENABLE_M != 0) begin
                    idx = IDX_M_BASE + {3'd0, funct3};
                end
            end
            OPC_OP_IMM: begin
                unique case (funct3)
                    3'd0: idx = IDX_ADDI;
                    3'd2: idx = IDX_SLTI;
                    3'd3: idx = IDX_SLTIU;
                    3'd4: idx = IDX_XORI;
                    3'd6: idx = IDX_ORI;
                    3'd7: idx = IDX_ANDI;
                    3'd1: if (funct7 == F7_BASE) idx = IDX_SLLI;
                    default: begin
                        // funct3 5: shift type selected by funct7
                        if (funct7 == F7_BASE)     idx = IDX_SRLI;
                        else if (funct7 == F7_ALT) idx = IDX_SRAI;
                    end
                endcase
            end
            OPC_LOAD:   idx = IDX_LOAD;
            OPC_STORE:  idx = IDX_STORE;
            OPC_BRANCH: idx = IDX_BRANCH;
            OPC_LUI:    idx = IDX_LUI;
            OPC_AUIPC:  idx = IDX_AUIPC;
            OPC_JAL:    idx = IDX_JAL;
            OPC_JALR:   idx = IDX_JALR;
            default:    idx = IDX_ILLEGAL;
        endcase
    end

    assign illegal = (idx == IDX_ILLEGAL);
endmodule

// File: rtl/ucode_sequencer.sv
// Micro-code sequencer: latches an instruction, then walks the micro-PC
// through the ROM until uop_last, with a step watchdog and trap entry.
module ucode_sequencer
    import ucode_pkg::*;
#(
    parameter int                 UADDR_W     = 6,
    parameter int                 ENTRY_SHIFT = 0,
    parameter int                 ENABLE_M    = 0,
    parameter int                 MAX_STEPS   = 8,
    parameter logic [UADDR_W-1:0] TRAP_ADDR   = '1
) (
    input logic                clk,
    input logic                reset,
    ucode_sequencer_if.master  bus
);
    localparam int CNT_W = $clog2(MAX_STEPS + 1);

    state_t             state, state_n;
    logic [UADDR_W-1:0] addr_q, addr_n;
    logic [31:0]        iq_q, iq_n;
    logic               ill_q, ill_n;
    logic               fault_q, fault_n;
    logic               valid_q;
    logic [CNT_W-1:0]   cnt_q, cnt_n;

    logic [5:0]         dec_idx;
    logic               dec_ill;
    logic [UADDR_W-1:0] entry;
    logic               uop_hs, seq_done, accept, last_step;

    rv32_entry_decode #(.ENABLE_M(ENABLE_M)) u_dec (
        .instr   (bus.instr),
        .idx     (dec_idx),
        .illegal (dec_ill)
    );

    assign entry     = UADDR_W'(entry_addr(dec_idx, ENTRY_SHIFT));
    assign uop_hs    = valid_q && bus.uop_ready;
    assign seq_done  = (state == RUN) && uop_hs && bus.uop_last;
    assign last_step = ((cnt_q + CNT_W'(1)) == CNT_W'(MAX_STEPS)) || (addr_q == '1);

    // Taking a new instruction while the last micro-op retires avoids a bubble.
    assign bus.instr_ready = !reset && ((state == IDLE) || seq_done);
    assign accept          = bus.instr_ready && bus.instr_valid;

    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        iq_n    = iq_q;
        ill_n   = ill_q;
        cnt_n   = cnt_q;
        fault_n = fault_q;
        if (accept) begin
            state_n = RUN;
            addr_n  = entry;
            iq_n    = bus.instr;
            ill_n   = dec_ill;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: ;
                RUN: begin
                    if (uop_hs) begin
                        if (bus.uop_last) begin
                            state_n = IDLE;
                        end else if (last_step) begin
                            state_n = TRAP;
                            addr_n  = TRAP_ADDR;
                            fault_n = 1'b1;
                        end else begin
                            addr_n = addr_q + UADDR_W'(1);
                            cnt_n  = cnt_q + CNT_W'(1);
                        end
                    end
                end
                TRAP: if (uop_hs) state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            iq_q    <= '0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_n;
            addr_q  <= addr_n;
            iq_q    <= iq_n;
            ill_q   <= ill_n;
            cnt_q   <= cnt_n;
            fault_q <= fault_n;
            valid_q <= (state_n != IDLE);
        end
    end

    assign bus.uop_valid   = valid_q;
    assign bus.uop_addr    = addr_q;
    assign bus.instr_q     = iq_q;
    assign bus.uop_illegal = ill_q;
    assign bus.fault       = fault_q;
endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer: three instances cover the default
// build, an 8-bit/shift-2 build and an M-extension build.
module tb_ucode_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    localparam logic [31:0] I_ADD = 32'h002081B3;
    localparam logic [31:0] I_SUB = 32'h40208233;
    localparam logic [31:0] I_LW  = 32'h0000A183;
    localparam logic [31:0] I_MUL = 32'h022081B3;

    always #5 clk = ~clk;

    ucode_sequencer_if #(.UADDR_W(6)) ifa ();
    ucode_sequencer_if #(.UADDR_W(8)) ifb ();
    ucode_sequencer_if #(.UADDR_W(6)) ifc ();

    ucode_sequencer #(.UADDR_W(6)) duta (.clk(clk), .reset(reset), .bus(ifa));
    ucode_sequencer #(.UADDR_W(8), .ENTRY_SHIFT(2)) dutb (.clk(clk), .reset(reset), .bus(ifb));
    ucode_sequencer #(.UADDR_W(6), .ENABLE_M(1)) dutc (.clk(clk), .reset(reset), .bus(ifc));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ifa.instr_valid = 0; ifa.instr = 0; ifa.uop_ready = 0; ifa.uop_last = 0;
        ifb.instr_valid = 0; ifb.instr = 0; ifb.uop_ready = 0; ifb.uop_last = 0;
        ifc.instr_valid = 0; ifc.instr = 0; ifc.uop_ready = 0; ifc.uop_last = 0;
        reset = 1;
        step(); step();
        vectors++;
        if (ifa.instr_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready_in_reset got %b exp 0", ifa.instr_ready); end
        reset = 0;
        #1;
        vectors++;
        if ({ifa.uop_valid, ifa.uop_addr, ifa.uop_illegal, ifa.fault} !== 9'd0) begin
            miscompares++; $display("FAIL rst_outputs got v=%b a=%0d i=%b f=%b exp all 0", ifa.uop_valid, ifa.uop_addr, ifa.uop_illegal, ifa.fault);
        end
        vectors++;
        if (ifa.instr_q !== 32'd0) begin miscompares++; $display("FAIL rst_instr_q got %h exp 0", ifa.instr_q); end
        vectors++;
        if (ifa.instr_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready_after got %b exp 1", ifa.instr_ready); end
    endtask

    task automatic test_add();
        ifa.instr = I_ADD; ifa.instr_valid = 1; ifa.uop_ready = 1; ifa.uop_last = 1;
        step();
        ifa.instr_valid = 0;
        vectors++;
        if (ifa.uop_valid !== 1'b1 || ifa.uop_addr !== 6'd1) begin
            miscompares++; $display("FAIL add_entry got v=%b a=%0d exp v=1 a=1", ifa.uop_valid, ifa.uop_addr);
        end
        vectors++;
        if (ifa.uop_illegal !== 1'b0 || ifa.instr_q !== I_ADD) begin
            miscompares++; $display("FAIL add_latch got ill=%b iq=%h exp ill=0 iq=%h", ifa.uop_illegal, ifa.instr_q, I_ADD);
        end
        step();
        vectors++;
        if (ifa.uop_valid !== 1'b0 || ifa.instr_ready !== 1'b1) begin
            miscompares++; $display("FAIL add_idle got v=%b rdy=%b exp v=0 rdy=1", ifa.uop_valid, ifa.instr_ready);
        end
    endtask

    task automatic test_load_shift();
        ifb.instr = I_LW; ifb.instr_valid = 1; ifb.uop_ready = 1; ifb.uop_last = 0;
        step();
        ifb.instr_valid = 0;
        vectors++;
        if (ifb.uop_addr !== 8'd44) begin miscompares++; $display("FAIL lw_uop0 got %0d exp 44", ifb.uop_addr); end
        step();
        vectors++;
        if (ifb.uop_addr !== 8'd45 || ifb.instr_ready !== 1'b0) begin
            miscompares++; $display("FAIL lw_uop1 got a=%0d rdy=%b exp a=45 rdy=0", ifb.uop_addr, ifb.instr_ready);
        end
        step();
        ifb.uop_last = 1;
        #1;
        vectors++;
        if (ifb.uop_addr !== 8'd46 || ifb.instr_ready !== 1'b1) begin
            miscompares++; $display("FAIL lw_uop2 got a=%0d rdy=%b exp a=46 rdy=1", ifb.uop_addr, ifb.instr_ready);
        end
        step();
        ifb.uop_last = 0;
        vectors++;
        if (ifb.uop_valid !== 1'b0) begin miscompares++; $display("FAIL lw_done got v=%b exp 0", ifb.uop_valid); end
    endtask

    task automatic test_mul();
        ifc.instr = I_MUL; ifc.instr_valid = 1; ifc.uop_ready = 1; ifc.uop_last = 1;
        ifa.instr = I_MUL; ifa.instr_valid = 1; ifa.uop_ready = 1; ifa.uop_last = 1;
        step();
        ifc.instr_valid = 0; ifa.instr_valid = 0;
        vectors++;
        if (ifc.uop_addr !== 6'd27 || ifc.uop_illegal !== 1'b0) begin
            miscompares++; $display("FAIL mul_m_on got a=%0d ill=%b exp a=27 ill=0", ifc.uop_addr, ifc.uop_illegal);
        end
        vectors++;
        if (ifa.uop_addr !== 6'd63 || ifa.uop_illegal !== 1'b1) begin
            miscompares++; $display("FAIL mul_m_off got a=%0d ill=%b exp a=63 ill=1", ifa.uop_addr, ifa.uop_illegal);
        end
        step();
        vectors++;
        if (ifa.uop_valid !== 1'b0 || ifa.fault !== 1'b0) begin
            miscompares++; $display("FAIL mul_m_off_end got v=%b f=%b exp v=0 f=0", ifa.uop_valid, ifa.fault);
        end
    endtask

    task automatic test_watchdog();
        ifa.instr = I_ADD; ifa.instr_valid = 1; ifa.uop_ready = 1; ifa.uop_last = 0;
        step();
        ifa.instr_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            vectors++;
            if (ifa.uop_addr !== 6'(k) || ifa.fault !== 1'b0) begin
                miscompares++; $display("FAIL wd_walk%0d got a=%0d f=%b exp a=%0d f=0", k, ifa.uop_addr, ifa.fault, k);
            end
            step();
        end
        ifa.uop_last = 1;
        #1;
        vectors++;
        if (ifa.uop_addr !== 6'd63 || ifa.fault !== 1'b1 || ifa.uop_valid !== 1'b1) begin
            miscompares++; $display("FAIL wd_trap got a=%0d f=%b v=%b exp a=63 f=1 v=1", ifa.uop_addr, ifa.fault, ifa.uop_valid);
        end
        vectors++;
        if (ifa.instr_ready !== 1'b0) begin miscompares++; $display("FAIL wd_trap_rdy got %b exp 0", ifa.instr_ready); end
        step();
        ifa.uop_last = 0;
        vectors++;
        if (ifa.uop_valid !== 1'b0 || ifa.fault !== 1'b1) begin
            miscompares++; $display("FAIL wd_sticky got v=%b f=%b exp v=0 f=1", ifa.uop_valid, ifa.fault);
        end
    endtask

    task automatic test_back_to_back();
        ifa.instr = I_ADD; ifa.instr_valid = 1; ifa.uop_ready = 0; ifa.uop_last = 0;
        step();
        ifa.instr_valid = 0; ifa.instr = I_SUB;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (ifa.uop_addr !== 6'd1 || ifa.instr_q !== I_ADD || ifa.uop_valid !== 1'b1) begin
                miscompares++; $display("FAIL bp_hold%0d got a=%0d iq=%h v=%b exp a=1 iq=%h v=1", k, ifa.uop_addr, ifa.instr_q, ifa.uop_valid, I_ADD);
            end
            step();
        end
        ifa.uop_ready = 1; ifa.uop_last = 1; ifa.instr_valid = 1;
        #1;
        vectors++;
        if (ifa.instr_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready got %b exp 1", ifa.instr_ready); end
        step();
        ifa.instr_valid = 0;
        vectors++;
        if (ifa.uop_valid !== 1'b1 || ifa.uop_addr !== 6'd2 || ifa.instr_q !== I_SUB) begin
            miscompares++; $display("FAIL b2b_next got v=%b a=%0d iq=%h exp v=1 a=2 iq=%h", ifa.uop_valid, ifa.uop_addr, ifa.instr_q, I_SUB);
        end
        step();
        vectors++;
        if (ifa.uop_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_done got v=%b exp 0", ifa.uop_valid); end
    endtask

    task automatic test_reset_mid();
        ifa.instr = I_ADD; ifa.instr_valid = 1; ifa.uop_ready = 1; ifa.uop_last = 0;
        step();
        ifa.instr_valid = 0;
        vectors++;
        if (ifa.uop_valid !== 1'b1 || ifa.fault !== 1'b1) begin
            miscompares++; $display("FAIL rm_pre got v=%b f=%b exp v=1 f=1", ifa.uop_valid, ifa.fault);
        end
        reset = 1;
        step();
        reset = 0;
        vectors++;
        if (ifa.uop_valid !== 1'b0 || ifa.uop_addr !== 6'd0 || ifa.fault !== 1'b0) begin
            miscompares++; $display("FAIL rm_abort got v=%b a=%0d f=%b exp v=0 a=0 f=0", ifa.uop_valid, ifa.uop_addr, ifa.fault);
        end
        ifa.instr_valid = 1; ifa.uop_last = 1;
        #1;
        vectors++;
        if (ifa.instr_ready !== 1'b1) begin miscompares++; $display("FAIL rm_ready got %b exp 1", ifa.instr_ready); end
        step();
        ifa.instr_valid = 0;
        vectors++;
        if (ifa.uop_valid !== 1'b1 || ifa.uop_addr !== 6'd1) begin
            miscompares++; $display("FAIL rm_add got v=%b a=%0d exp v=1 a=1", ifa.uop_valid, ifa.uop_addr);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_load_shift();
        test_mul();
        test_watchdog();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
